icache_refill_ctrl: RTL and testbench

- Sequences instruction-cache line refills for the fetch stage.
- On an icache miss it stalls fetch, issues one burst read on the AXI-style read channel at the block-aligned PC, and assembles 8 x 64-bit beats into a 512-bit line.
- It then pulses the icache write enable for one cycle and releases the stall.
- Sits between the fetch stage (icache hit, aligned read address) and the memory read port.

---
 rtl/icache_refill_ctrl_pkg.sv | 17 +
 rtl/icache_refill_ctrl_line_buffer.sv | 44 ++++
 rtl/icache_refill_ctrl.sv | 163 ++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared states and constants for the instruction-cache line refill controller.
package icache_refill_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    ERR
  } refill_state_t;

  localparam int         BEATS         = 8;
  localparam int         LINE_OFFSET_W = 6;
  localparam int         CNT_W         = $clog2(BEATS);
  localparam logic [1:0] RESP_OKAY     = 2'b00;

endpackage

// File: rtl/icache_refill_ctrl_line_buffer.sv
// Beat-indexed line assembly register: beat N lands in bits [N*BEAT_WIDTH +: BEAT_WIDTH].
module refill_line_buffer
  import icache_refill_ctrl_pkg::*;
#(
  parameter int BEAT_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        beat_valid,
  input  logic [BEAT_WIDTH-1:0]       data,
  output logic [BEAT_WIDTH*BEATS-1:0] line,
  output logic                        last_beat
);

  logic [BEAT_WIDTH*BEATS-1:0] line_q, line_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  // Clearing only rewinds the counter; stale line bits are overwritten by the next burst.
  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (beat_valid) begin
      line_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = data;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line      = line_q;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// Icache miss refill sequencer: one 8-beat burst read per miss, then a one-cycle line write.
// Optional miss performance counter enabled by defining ICACHE_REFILL_PERF_EN.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int BEAT_WIDTH  = 64
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_fetch_req,
  input  logic                   i_icache_hit,
  input  logic [ADDR_WIDTH-1:0]  i_read_addr,
  output logic                   o_stall_fetch,
  output logic                   o_arvalid,
  input  logic                   i_arready,
  output logic [ADDR_WIDTH-1:0]  o_araddr,
  output logic [7:0]             o_arlen,
  input  logic                   i_rvalid,
  output logic                   o_rready,
  input  logic [BEAT_WIDTH-1:0]  i_rdata,
  input  logic                   i_rlast,
  input  logic [1:0]             i_rresp,
  output logic                   o_instr_we,
  output logic [BLOCK_WIDTH-1:0] o_instr_block,
  output logic                   o_refill_err,
  output logic [31:0]            o_miss_count
);

  refill_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  err_q, err_d;

  logic miss;
  logic buf_clear;
  logic beat_valid;
  logic last_beat;
  logic beat_err;
  logic miss_start;
  logic arvalid;
  logic rready;
  logic instr_we;
  logic refill_err;

  logic unused_addr_offset;
  assign unused_addr_offset = ^i_read_addr[LINE_OFFSET_W-1:0];

  assign miss = i_fetch_req & ~i_icache_hit;

  // A burst always runs to completion; rlast/count disagreement is treated as a failed refill.
  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    err_d      = err_q;
    buf_clear  = 1'b0;
    beat_valid = 1'b0;
    beat_err   = 1'b0;
    miss_start = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    instr_we   = 1'b0;
    refill_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss) begin
          araddr_d   = {i_read_addr[ADDR_WIDTH-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
          err_d      = 1'b0;
          buf_clear  = 1'b1;
          miss_start = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        arvalid = 1'b1;
        if (i_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        rready = 1'b1;
        if (i_rvalid) begin
          beat_valid = 1'b1;
          beat_err   = (i_rresp != RESP_OKAY) | (i_rlast != last_beat);
          err_d      = err_q | beat_err;
          if (i_rlast || last_beat) begin
            state_d = (err_q | beat_err) ? ERR : WRITE;
          end
        end
      end
      WRITE: begin
        instr_we = 1'b1;
        state_d  = IDLE;
      end
      ERR: begin
        refill_err = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q  <= IDLE;
      araddr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      err_q    <= err_d;
    end
  end

  refill_line_buffer #(
    .BEAT_WIDTH(BEAT_WIDTH)
  ) u_line_buffer (
    .clk       (i_clk),
    .rst       (i_arst),
    .clear     (buf_clear),
    .beat_valid(beat_valid),
    .data      (i_rdata),
    .line      (o_instr_block),
    .last_beat (last_beat)
  );

  // Stall covers the miss cycle itself so the PC holds before the FSM leaves IDLE.
  assign o_stall_fetch = (state_q != IDLE) | miss;
  assign o_arvalid     = arvalid;
  assign o_araddr      = araddr_q;
  assign o_arlen       = 8'(BEATS - 1);
  assign o_rready      = rready;
  assign o_instr_we    = instr_we;
  assign o_refill_err  = refill_err;

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    miss_count_d = miss_count_q;
    if (miss_start && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      miss_count_q <= '0;
    end else begin
      miss_count_q <= miss_count_d;
    end
  end

  assign o_miss_count = miss_count_q;
`else
  logic unused_miss_start;
  assign unused_miss_start = miss_start;
  assign o_miss_count      = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: normal, wait-state, error, early-rlast and reset refills.
module tb_icache_refill_ctrl;

  logic         clk;
  logic         arst;
  logic         fetch_req;
  logic         icache_hit;
  logic [63:0]  read_addr;
  logic         stall;
  logic         arvalid;
  logic         arready;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic         rvalid;
  logic         rready;
  logic [63:0]  rdata;
  logic         rlast;
  logic [1:0]   rresp;
  logic         instr_we;
  logic [511:0] instr_block;
  logic         refill_err;
  logic [31:0]  miss_count;

  int checks;
  int errors;

  icache_refill_ctrl dut (
    .i_clk        (clk),
    .i_arst       (arst),
    .i_fetch_req  (fetch_req),
    .i_icache_hit (icache_hit),
    .i_read_addr  (read_addr),
    .o_stall_fetch(stall),
    .o_arvalid    (arvalid),
    .i_arready    (arready),
    .o_araddr     (araddr),
    .o_arlen      (arlen),
    .i_rvalid     (rvalid),
    .o_rready     (rready),
    .i_rdata      (rdata),
    .i_rlast      (rlast),
    .i_rresp      (rresp),
    .o_instr_we   (instr_we),
    .o_instr_block(instr_block),
    .o_refill_err (refill_err),
    .o_miss_count (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit req, input bit hit, input logic [63:0] addr);
    fetch_req  = req;
    icache_hit = hit;
    read_addr  = addr;
  endtask

  function automatic logic [511:0] expBlock(input logic [63:0] base);
    logic [511:0] b;
    for (int k = 0; k < 8; k++) b[k*64 +: 64] = base + 64'(k);
    return b;
  endfunction

  // Memory-side responder; beat k carries base+k. Returns the cycle (edges after the call) of the
  // we/err pulse, or of the reset injection when rstBeat is reached.
  task automatic runRefill(input logic [63:0] expAddr, input int arWait, input bit gapped,
                           input logic [63:0] base, input int errBeat, input int lastBeat,
                           input int rstBeat, output int doneAt, output int weNum, output int errNum);
    int beat;
    int arLeft;
    bit skip;
    bit done;
    beat = 0; arLeft = arWait; skip = gapped; done = 0;
    doneAt = -1; weNum = 0; errNum = 0;
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      @(posedge clk); #1;
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      if (instr_we) weNum++;
      if (refill_err) errNum++;
      if (instr_we || refill_err) begin
        done = 1; doneAt = cyc;
      end else begin
        if (arvalid) begin
          checkOutput("araddr", araddr, expAddr);
          checkOutput("arlen", arlen, 8'd7);
          if (arLeft > 0) arLeft--;
          else arready = 1'b1;
        end
        if (rready && beat < 8) begin
          if (gapped && skip) begin
            skip = 0;
          end else begin
            rvalid = 1'b1;
            rdata  = base + 64'(beat);
            rresp  = (beat == errBeat) ? 2'b10 : 2'b00;
            rlast  = (beat == lastBeat);
            if (beat == rstBeat) begin
              arst = 1'b1; fetch_req = 1'b0; done = 1; doneAt = cyc;
            end
            beat++;
            skip = gapped;
          end
        end
      end
    end
    checkOutput("refill_done", done, 1);
  endtask

  int doneAt, weNum, errNum;
  int expCount;

  initial begin
    checks = 0; errors = 0;
    arst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
    applyStimulus(0, 0, 64'h0);
    #2;
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_rready", rready, 0);
    checkOutput("rst_we", instr_we, 0);
    checkOutput("rst_err", refill_err, 0);
    checkOutput("rst_araddr", araddr, 0);
    checkOutput("rst_block", instr_block, 0);
    checkOutput("rst_stall", stall, 0);
    @(posedge clk); #1;
    arst = 1'b0;

    // No refill on a hit or without a fetch request
    applyStimulus(1, 1, 64'h1000); #1;
    checkOutput("hit_stall", stall, 0);
    applyStimulus(0, 0, 64'h1000); #1;
    checkOutput("noreq_stall", stall, 0);
    @(posedge clk); #1;
    checkOutput("noreq_arvalid", arvalid, 0);

    // 1: zero-wait miss at 0x1044, beats 0..7; we in the 11th cycle counting the miss cycle as 1
    applyStimulus(1, 0, 64'h1044); #1;
    checkOutput("t1_miss_stall", stall, 1);
    runRefill(64'h1040, 0, 0, 64'h0, -1, 7, -1, doneAt, weNum, errNum);
    checkOutput("t1_latency", doneAt, 10);
    checkOutput("t1_we_count", weNum, 1);
    checkOutput("t1_block", instr_block, expBlock(64'h0));
    checkOutput("t1_beat7", instr_block[511:448], 64'h7);
    checkOutput("t1_write_stall", stall, 1);
    applyStimulus(1, 1, 64'h1044);
    @(posedge clk); #1;
    checkOutput("t1_stall_release", stall, 0);
    checkOutput("t1_we_single", instr_we, 0);

    // 2: arready after 3 waits, rvalid every other cycle
    applyStimulus(1, 0, 64'h1078); #1;
    runRefill(64'h1040, 3, 1, 64'h0, -1, 7, -1, doneAt, weNum, errNum);
    checkOutput("t2_latency", doneAt, 21);
    checkOutput("t2_we_count", weNum, 1);
    checkOutput("t2_block", instr_block, expBlock(64'h0));
    applyStimulus(1, 1, 64'h1078);
    @(posedge clk); #1;
    checkOutput("t2_we_single", instr_we, 0);

    // 3: SLVERR on beat 3, then retry while still missing
    applyStimulus(1, 0, 64'h2000); #1;
    runRefill(64'h2000, 0, 0, 64'h100, 3, 7, -1, doneAt, weNum, errNum);
    checkOutput("t3_err_at", doneAt, 10);
    checkOutput("t3_err_count", errNum, 1);
    checkOutput("t3_no_we", weNum, 0);
    @(posedge clk); #1;
    checkOutput("t3_err_single", refill_err, 0);
    checkOutput("t3_idle_we", instr_we, 0);
    checkOutput("t3_idle_stall", stall, 1);
    @(posedge clk); #1;
    checkOutput("t3_retry_arvalid", arvalid, 1);
    checkOutput("t3_retry_araddr", araddr, 64'h2000);
    runRefill(64'h2000, 0, 0, 64'h200, -1, 7, -1, doneAt, weNum, errNum);
    checkOutput("t3_retry_we", weNum, 1);
    checkOutput("t3_retry_block", instr_block, expBlock(64'h200));
    applyStimulus(1, 1, 64'h2000);
    @(posedge clk); #1;

    // 4: rlast early on beat 5
    applyStimulus(1, 0, 64'h3010); #1;
    runRefill(64'h3000, 0, 0, 64'h300, -1, 5, -1, doneAt, weNum, errNum);
    checkOutput("t4_err_at", doneAt, 8);
    checkOutput("t4_err_count", errNum, 1);
    checkOutput("t4_no_we", weNum, 0);
    applyStimulus(0, 0, 64'h3010);
    @(posedge clk); #1;
    checkOutput("t4_idle_stall", stall, 0);
    checkOutput("t4_idle_arvalid", arvalid, 0);
    checkOutput("t4_err_single", refill_err, 0);

    // 5: reset during beat 4, then a fresh burst
    applyStimulus(1, 0, 64'h4000); #1;
    runRefill(64'h4000, 0, 0, 64'h400, -1, 7, 4, doneAt, weNum, errNum);
    #1;
    checkOutput("t5_rst_arvalid", arvalid, 0);
    checkOutput("t5_rst_rready", rready, 0);
    checkOutput("t5_rst_we", instr_we, 0);
    checkOutput("t5_rst_err", refill_err, 0);
    checkOutput("t5_rst_araddr", araddr, 0);
    checkOutput("t5_rst_block", instr_block, 0);
    checkOutput("t5_rst_stall", stall, 0);
    checkOutput("t5_rst_count", miss_count, 0);
    rvalid = 1'b0; rlast = 1'b0;
    arst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1, 0, 64'h5008); #1;
    runRefill(64'h5000, 0, 0, 64'hABCD_0000_1111_0000, -1, 7, -1, doneAt, weNum, errNum);
    checkOutput("t5_latency", doneAt, 10);
    checkOutput("t5_we_count", weNum, 1);
    checkOutput("t5_block", instr_block, expBlock(64'hABCD_0000_1111_0000));
    applyStimulus(1, 1, 64'h5008);
    @(posedge clk); #1;

    // 6: two more misses, three since the reset
    applyStimulus(1, 0, 64'h6000); #1;
    runRefill(64'h6000, 0, 0, 64'h600, -1, 7, -1, doneAt, weNum, errNum);
    applyStimulus(1, 1, 64'h6000);
    @(posedge clk); #1;
    applyStimulus(1, 0, 64'h7000); #1;
    runRefill(64'h7000, 0, 0, 64'h700, -1, 7, -1, doneAt, weNum, errNum);
    checkOutput("t6_block", instr_block, expBlock(64'h700));
    applyStimulus(1, 1, 64'h7000);
    @(posedge clk); #1;
`ifdef ICACHE_REFILL_PERF_EN
    expCount = 3;
`else
    expCount = 0;
`endif
    checkOutput("t6_miss_count", miss_count, 32'(expCount));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
